// File: rtl/csi2_pkg.sv
// CSI-2 packet data-type constants and the frame sequencer state type.
// Shared by the sequencer top and its payload counter.
package csi2_pkg;

    localparam logic [7:0] DT_FRAME_START = 8'h00;
    localparam logic [7:0] DT_FRAME_END   = 8'h01;
    localparam logic [7:0] DT_LINE_START  = 8'h02;
    localparam logic [7:0] DT_LINE_END    = 8'h03;
    localparam logic [7:0] DT_LONG_MIN    = 8'h10;
    localparam logic [7:0] DT_LONG_MAX    = 8'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        LINE  = 2'd2
    } seq_state_t;

    function automatic logic is_long_packet(input logic [7:0] data_type);
        return (data_type >= DT_LONG_MIN) && (data_type <= DT_LONG_MAX);
    endfunction

    // ceil(word_count / 4) in 17 bits so 16'hFFFD..16'hFFFF cannot wrap.
    function automatic logic [15:0] beats_for_words(input logic [15:0] word_count);
        logic [16:0] sum;
        sum = {1'b0, word_count} + 17'd3;
        return {1'b0, sum[16:2]};
    endfunction

endpackage

// File: rtl/payload_counter.sv
// Saturating payload beat counter with the expected-length latch and compare.
// length_ok already includes a beat arriving in the same cycle.
module payload_counter
    import csi2_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        beat,
    input  logic [15:0] word_count,
    output logic        length_ok
);

    logic [15:0] beat_count;
    logic [15:0] expected_beats;
    logic [15:0] beat_sum;

    assign beat_sum  = (beat && (beat_count != 16'hFFFF)) ? beat_count + 16'd1 : beat_count;
    assign length_ok = (beat_sum == expected_beats);

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_count     <= 16'd0;
            expected_beats <= 16'd0;
        end else begin
            beat_count <= start ? 16'd0 : beat_sum;
            if (start) begin
                expected_beats <= beats_for_words(word_count);
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Tracks CSI-2 frame/line envelopes for one virtual channel from decoded headers,
// forwards line payload and flags sync and length errors.
module frame_sequencer
    import csi2_pkg::*;
#(
    parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            header_valid,
    input  logic [1:0]      virtual_channel,
    input  logic [7:0]      image_data_type,
    input  logic [15:0]     word_count,
    input  logic            image_data_enable,
    input  logic [3:0][7:0] image_data,
    input  logic            packet_end,
    output logic            frame_valid,
    output logic            line_valid,
    output logic [15:0]     frame_number,
    output logic [15:0]     line_number,
    output logic [3:0][7:0] pixel_data,
    output logic            pixel_data_valid,
    output logic            error_sync,
    output logic            error_length,
    output seq_state_t      debug_state
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [15:0] frame_next;
    logic [15:0] line_next;
    logic        sync_next;
    logic        length_next;
    logic        start_line;
    logic        length_ok;
    logic        hdr_match;
    logic        hdr_fs;
    logic        hdr_fe;
    logic        hdr_long;
    logic        beat_accept;

    assign hdr_match   = header_valid && (virtual_channel == VIRTUAL_CHANNEL);
    assign hdr_fs      = (image_data_type == DT_FRAME_START);
    assign hdr_fe      = (image_data_type == DT_FRAME_END);
    assign hdr_long    = is_long_packet(image_data_type);
    assign beat_accept = (state == LINE) && image_data_enable;

    assign frame_valid = (state != IDLE);
    assign line_valid  = (state == LINE);
    assign debug_state = state;

    payload_counter u_payload_counter (
        .clock      (clock),
        .reset      (reset),
        .start      (start_line),
        .beat       (beat_accept),
        .word_count (word_count),
        .length_ok  (length_ok)
    );

    // packet_end is resolved first; the header then acts on the resulting state.
    always_comb begin
        state_next  = state;
        frame_next  = frame_number;
        line_next   = line_number;
        sync_next   = 1'b0;
        length_next = 1'b0;
        start_line  = 1'b0;

        if ((state == LINE) && packet_end) begin
            state_next  = FRAME;
            line_next   = line_number + 16'd1;
            length_next = !length_ok;
        end

        // A frame-level header inside an unterminated line forces the line closed.
        if (hdr_match && (state_next == LINE) && (hdr_fs || hdr_fe || hdr_long)) begin
            sync_next  = 1'b1;
            state_next = FRAME;
            line_next  = line_number + 16'd1;
        end

        if (hdr_match) begin
            case (state_next)
                IDLE: begin
                    if (hdr_fs) begin
                        state_next = FRAME;
                        frame_next = word_count;
                        line_next  = 16'd0;
                    end else if (hdr_fe || hdr_long) begin
                        sync_next = 1'b1;
                    end
                end
                FRAME: begin
                    if (hdr_long) begin
                        state_next = LINE;
                        start_line = 1'b1;
                    end else if (hdr_fe) begin
                        state_next = IDLE;
                    end else if (hdr_fs) begin
                        sync_next  = 1'b1;
                        frame_next = word_count;
                        line_next  = 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            frame_number     <= 16'd0;
            line_number      <= 16'd0;
            error_sync       <= 1'b0;
            error_length     <= 1'b0;
            pixel_data       <= '0;
            pixel_data_valid <= 1'b0;
        end else begin
            state            <= state_next;
            frame_number     <= frame_next;
            line_number      <= line_next;
            error_sync       <= sync_next;
            error_length     <= length_next;
            pixel_data_valid <= beat_accept;
            if (beat_accept) begin
                pixel_data <= image_data;
            end
        end
    end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter VIRTUAL_CHANNEL, default 2'd0, the only virtual channel sequenced; packets on other channels are ignored.
REQ-002 SHALL have ports: clock  input  1  sole clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 header_valid  input  1  one-cycle strobe; a decoded packet header is present on the header inputs.
REQ-005 virtual_channel  input  2  header virtual channel.
REQ-006 image_data_type  input  8  header data type.
REQ-007 word_count  input  16  header word count; for FS/FE this is the frame number.
REQ-008 image_data_enable  input  1  one payload beat (4 bytes) valid this cycle.
REQ-009 image_data  input  4x8  payload bytes, [0] first on the wire.
REQ-010 packet_end  input  1  one-cycle strobe; the current packet (payload and CRC) has finished.
REQ-011 frame_valid, line_valid  output  1 each  frame and line envelopes.
REQ-012 frame_number, line_number  output  16 each  current frame number and zero-based line index.
REQ-013 pixel_data  output  4x8 and pixel_data_valid  output  1  payload forwarded while in LINE.
REQ-014 error_sync, error_length  output  1 each  one-cycle error pulses.

Function
REQ-015 SHALL use states IDLE, FRAME and LINE, and act on a header only when header_valid=1 and virtual_channel=VIRTUAL_CHANNEL.
REQ-016 IDLE + FS (8'h00): go to FRAME; frame_number<=word_count, line_number<=0.
REQ-017 IDLE + FE or long packet (type 8'h10..8'h3F): pulse error_sync and stay in IDLE.
REQ-018 FRAME + long packet: go to LINE; latch expected_beats=ceil(word_count/4) (17-bit arithmetic, no overflow); clear beat counter.
REQ-019 FRAME + FE: go to IDLE. FRAME + FS: pulse error_sync, reload frame_number, clear line_number, stay in FRAME.
REQ-020 LS (8'h02), LE (8'h03), generic short packets (8'h08..8'h0F) and all other types SHALL cause no state change.
REQ-021 LINE + image_data_enable: increment the 16-bit beat counter, saturating at 16'hFFFF; forward the beat.
REQ-022 LINE + packet_end: go to FRAME; line_number increments with 16-bit wrap; pulse error_length if beat count != expected_beats.
REQ-023 LINE + qualifying header without a prior packet_end: pulse error_sync, close the line as in REQ-022 without the length check, then process the header from FRAME.
REQ-024 On packet_end and header_valid in the same cycle: process packet_end first, then the header, both in that one cycle.
REQ-025 image_data_enable together with packet_end SHALL count and forward the beat before the length check.
REQ-026 frame_valid=1 in FRAME or LINE; line_valid=1 in LINE only. Both registered: they change the cycle after the causing strobe.
REQ-027 pixel_data/pixel_data_valid SHALL be registered: 1-cycle latency from image_data_enable; valid only for beats accepted in LINE.
REQ-028 Beats outside LINE SHALL be dropped silently; the word count of a zero-length long packet gives expected_beats=0.

Reset
REQ-029 reset=1 SHALL force IDLE and zero every output and counter on the next edge, including mid-line; in-progress errors are not reported.
REQ-030 The first header is honoured on the first cycle with reset=0.

Structure
REQ-031 Shared package csi2_pkg SHALL hold the data-type constants (DT_FRAME_START, DT_FRAME_END, DT_LINE_START, DT_LINE_END, long-packet range bounds) and the state enum.
REQ-032 One sub-module, payload_counter, SHALL hold the saturating beat counter, the expected_beats latch and the compare.

Verification
REQ-033 FS(wc=16'h0007), long(0x2A, wc=8) with 2 beats + end, FE -> frame_number=7; line_valid high for 2 cycles of beats; line_number 0->1; no errors.
REQ-034 Long wc=6 with 2 beats (ceil=2) -> no error; wc=9 with 2 beats -> one error_length pulse on the cycle after packet_end.
REQ-035 FE in IDLE -> error_sync pulse, frame_valid stays 0; FS,FS(wc=3) -> one error_sync pulse, frame_number=3.
REQ-036 Header on VIRTUAL_CHANNEL=1 while the parameter is 0 -> no state or output change.
REQ-037 reset asserted mid-LINE after 1 beat -> all outputs 0 next cycle; a following FS restarts cleanly.
REQ-038 packet_end, image_data_enable and an FE header in one cycle -> beat forwarded, line closed, state IDLE; 65536 lines -> line_number wraps to 0.
